// File: rtl/fetch_unit.sv
// Y86-64 fetch stage: byte-serial instruction fetch over a req/ack memory port,
// assembles one instruction and hands it to decode, then waits for the next PC.
module fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_load,
  input  logic [63:0] pc_new,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic [7:0]  imem_rdata,
  input  logic        imem_ack,
  input  logic        imem_err,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  icode,
  output logic [3:0]  ifun,
  output logic [3:0]  rA,
  output logic [3:0]  rB,
  output logic [63:0] valC,
  output logic [63:0] valP,
  output logic [2:0]  stat
);

  localparam int unsigned XLEN  = 64;
  localparam int unsigned NIB   = 4;
  localparam int unsigned CNT_W = 3;
  localparam int unsigned STATW = 3;

  localparam logic [STATW-1:0] STAT_AOK = 3'd1;
  localparam logic [STATW-1:0] STAT_HLT = 3'd2;
  localparam logic [STATW-1:0] STAT_ADR = 3'd3;
  localparam logic [STATW-1:0] STAT_INS = 3'd4;
  localparam logic [NIB-1:0]   REG_NONE = 4'hF;

  typedef enum logic [2:0] {
    S_FETCH, S_REG, S_CONST, S_REPORT, S_OUTPUT, S_WAIT_PC, S_STOP
  } state_e;

  state_e             state_q, state_d;
  logic [XLEN-1:0]    pc_q, pc_d;
  logic [XLEN-1:0]    addr_q, addr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               out_valid_q, out_valid_d;
  logic [NIB-1:0]     icode_q, icode_d, ifun_q, ifun_d;
  logic [NIB-1:0]     ra_q, ra_d, rb_q, rb_d;
  logic [XLEN-1:0]    valc_q, valc_d, valp_q, valp_d;
  logic [STATW-1:0]   stat_q, stat_d;

  function automatic logic [3:0] ins_len(input logic [NIB-1:0] ic);
    case (ic)
      4'h0, 4'h1, 4'h9:       ins_len = 4'd1;
      4'h2, 4'h6, 4'hA, 4'hB: ins_len = 4'd2;
      4'h7, 4'h8:             ins_len = 4'd9;
      4'h3, 4'h4, 4'h5:       ins_len = 4'd10;
      default:                ins_len = 4'd1;
    endcase
  endfunction

  function automatic logic is_legal(input logic [NIB-1:0] ic, input logic [NIB-1:0] fn);
    case (ic)
      4'h2, 4'h7:                    is_legal = (fn <= 4'd6);
      4'h6:                          is_legal = (fn <= 4'd3);
      4'hC, 4'hD, 4'hE, 4'hF:        is_legal = 1'b0;
      default:                       is_legal = (fn == 4'd0);
    endcase
  endfunction

  // Next-state and datapath updates
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    icode_d     = icode_q;
    ifun_d      = ifun_q;
    ra_d        = ra_q;
    rb_d        = rb_q;
    valc_d      = valc_q;
    valp_d      = valp_q;
    stat_d      = stat_q;

    case (state_q)
      S_FETCH: begin
        if (imem_ack) begin
          addr_d = addr_q + 64'd1;
          if (imem_err) begin
            stat_d  = STAT_ADR;
            state_d = S_REPORT;
          end else begin
            icode_d = imem_rdata[7:4];
            ifun_d  = imem_rdata[3:0];
            if (!is_legal(imem_rdata[7:4], imem_rdata[3:0])) begin
              stat_d  = STAT_INS;
              state_d = S_REPORT;
            end else if (ins_len(imem_rdata[7:4]) == 4'd1) begin
              if (imem_rdata[7:4] == 4'h0) stat_d = STAT_HLT;
              state_d = S_REPORT;
            end else if (imem_rdata[7:4] == 4'h7 || imem_rdata[7:4] == 4'h8) begin
              state_d = S_CONST;
            end else begin
              state_d = S_REG;
            end
          end
        end
      end
      S_REG: begin
        if (imem_ack) begin
          addr_d = addr_q + 64'd1;
          if (imem_err) begin
            stat_d  = STAT_ADR;
            state_d = S_REPORT;
          end else begin
            ra_d    = imem_rdata[7:4];
            rb_d    = imem_rdata[3:0];
            state_d = (ins_len(icode_q) == 4'd10) ? S_CONST : S_REPORT;
          end
        end
      end
      S_CONST: begin
        if (imem_ack) begin
          addr_d = addr_q + 64'd1;
          if (imem_err) begin
            stat_d  = STAT_ADR;
            state_d = S_REPORT;
          end else begin
            valc_d[{cnt_q, 3'b000} +: 8] = imem_rdata;
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) state_d = S_REPORT;
          end
        end
      end
      S_REPORT: begin
        valp_d      = pc_q + XLEN'(ins_len(icode_q));
        out_valid_d = 1'b1;
        state_d     = S_OUTPUT;
      end
      S_OUTPUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = (stat_q == STAT_AOK) ? S_WAIT_PC : S_STOP;
        end
      end
      S_WAIT_PC: begin
        // Fields return to their reset values so a faulting fetch reports only what it latched
        if (pc_load) begin
          pc_d    = pc_new;
          addr_d  = pc_new;
          cnt_d   = '0;
          icode_d = '0;
          ifun_d  = '0;
          ra_d    = REG_NONE;
          rb_d    = REG_NONE;
          valc_d  = '0;
          valp_d  = '0;
          stat_d  = STAT_AOK;
          state_d = S_FETCH;
        end
      end
      S_STOP: ;
      default: state_d = S_STOP;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      addr_q      <= RESET_PC;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      icode_q     <= '0;
      ifun_q      <= '0;
      ra_q        <= REG_NONE;
      rb_q        <= REG_NONE;
      valc_q      <= '0;
      valp_q      <= '0;
      stat_q      <= STAT_AOK;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      icode_q     <= icode_d;
      ifun_q      <= ifun_d;
      ra_q        <= ra_d;
      rb_q        <= rb_d;
      valc_q      <= valc_d;
      valp_q      <= valp_d;
      stat_q      <= stat_d;
    end
  end

  // Request is decoded from the state register so byte 0 can be acked in the first FETCH cycle
  assign imem_req  = !reset && (state_q == S_FETCH || state_q == S_REG || state_q == S_CONST);
  assign imem_addr = addr_q;
  assign out_valid = out_valid_q;
  assign icode     = icode_q;
  assign ifun      = ifun_q;
  assign rA        = ra_q;
  assign rB        = rb_q;
  assign valC      = valc_q;
  assign valP      = valp_q;
  assign stat      = stat_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a byte memory model that inserts a
// programmable number of wait cycles per byte and can fault one address.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        pc_load;
  logic [63:0] pc_new;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic [7:0]  imem_rdata;
  logic        imem_ack;
  logic        imem_err;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  icode, ifun, rA, rB;
  logic [63:0] valC, valP;
  logic [2:0]  stat;

  logic [7:0]  mem [0:255];
  int          wait_n;
  int          wcnt;
  logic        err_en;
  logic [63:0] err_addr;

  int tests_run = 0;
  int tests_failed = 0;

  fetch_unit #(.RESET_PC(64'h0)) dut (
    .clk(clk), .reset(reset), .pc_load(pc_load), .pc_new(pc_new),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_ack(imem_ack), .imem_err(imem_err),
    .out_valid(out_valid), .out_ready(out_ready),
    .icode(icode), .ifun(ifun), .rA(rA), .rB(rB),
    .valC(valC), .valP(valP), .stat(stat)
  );

  always #5 clk = ~clk;

  assign imem_ack   = imem_req && (wcnt >= wait_n);
  assign imem_rdata = mem[imem_addr[7:0]];
  assign imem_err   = err_en && (imem_addr == err_addr);

  always @(posedge clk) begin
    if (!imem_req || imem_ack) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic pulse_pc(input logic [63:0] a);
    pc_new  = a;
    pc_load = 1'b1;
    @(negedge clk);
    pc_load = 1'b0;
  endtask

  // Counts negedges until out_valid, starting from a given count
  task automatic wait_valid(input int start, output int cycles, output bit timed_out);
    cycles = start;
    timed_out = 1'b0;
    while (!out_valid && cycles < 200) begin
      @(negedge clk);
      cycles++;
    end
    if (!out_valid) timed_out = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    tests_run++;
    if (imem_req !== 1'b0 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: req=%b valid=%b required req=0 valid=0", imem_req, out_valid);
    end
    tests_run++;
    if (icode !== 4'h0 || ifun !== 4'h0 || rA !== 4'hF || rB !== 4'hF ||
        valC !== 64'h0 || valP !== 64'h0 || stat !== 3'd1) begin
      tests_failed++;
      $display("FAIL reset_fields: ic=%h fn=%h rA=%h rB=%h valC=%h valP=%h stat=%0d required 0 0 f f 0 0 1",
               icode, ifun, rA, rB, valC, valP, stat);
    end
  endtask

  task automatic test_irmovq();
    int cyc; bit to;
    clear_mem();
    mem[0] = 8'h30; mem[1] = 8'hF3; mem[2] = 8'h0A;
    wait_n = 0;
    reset = 1'b0;
    wait_valid(0, cyc, to);
    tests_run++;
    if (to || cyc != 11) begin
      tests_failed++;
      $display("FAIL irmovq_latency: got %0d cycles (timeout=%0b) required 11", cyc, to);
    end
    tests_run++;
    if (icode !== 4'h3 || ifun !== 4'h0 || rA !== 4'hF || rB !== 4'h3 ||
        valC !== 64'hA || valP !== 64'hA || stat !== 3'd1) begin
      tests_failed++;
      $display("FAIL irmovq_fields: ic=%h fn=%h rA=%h rB=%h valC=%h valP=%h stat=%0d required 3 0 f 3 a a 1",
               icode, ifun, rA, rB, valC, valP, stat);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b0 || imem_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL irmovq_accept: valid=%b req=%b required 0 0", out_valid, imem_req);
    end
  endtask

  task automatic test_jmp_wait();
    int cyc; bit to;
    mem[8'h20] = 8'h70; mem[8'h21] = 8'h00; mem[8'h22] = 8'h01;
    wait_n = 2;
    pulse_pc(64'h20);
    wait_valid(1, cyc, to);
    tests_run++;
    if (to || cyc != 29) begin
      tests_failed++;
      $display("FAIL jmp_latency: got %0d cycles (timeout=%0b) required 29", cyc, to);
    end
    tests_run++;
    if (icode !== 4'h7 || rA !== 4'hF || rB !== 4'hF || valC !== 64'h100 ||
        valP !== 64'h29 || stat !== 3'd1) begin
      tests_failed++;
      $display("FAIL jmp_fields: ic=%h rA=%h rB=%h valC=%h valP=%h stat=%0d required 7 f f 100 29 1",
               icode, rA, rB, valC, valP, stat);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    wait_n = 0;
  endtask

  task automatic test_halt();
    int cyc; bit to;
    logic seen_req;
    mem[8'h40] = 8'h10; mem[8'h41] = 8'h00;
    out_ready = 1'b1;
    pulse_pc(64'h40);
    wait_valid(1, cyc, to);
    tests_run++;
    if (to || cyc != 3 || icode !== 4'h1 || stat !== 3'd1 || valP !== 64'h41) begin
      tests_failed++;
      $display("FAIL nop: cyc=%0d to=%0b ic=%h stat=%0d valP=%h required 3 0 1 1 41",
               cyc, to, icode, stat, valP);
    end
    @(negedge clk);
    pulse_pc(64'h41);
    wait_valid(1, cyc, to);
    tests_run++;
    if (to || icode !== 4'h0 || stat !== 3'd2 || valP !== 64'h42) begin
      tests_failed++;
      $display("FAIL halt: to=%0b ic=%h stat=%0d valP=%h required 0 2 42", to, icode, stat, valP);
    end
    seen_req = 1'b0;
    pc_new = 64'h40;
    pc_load = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (imem_req) seen_req = 1'b1;
    end
    pc_load = 1'b0;
    out_ready = 1'b0;
    tests_run++;
    if (seen_req !== 1'b0 || out_valid !== 1'b0 || stat !== 3'd2) begin
      tests_failed++;
      $display("FAIL halt_stop: req_seen=%b valid=%b stat=%0d required 0 0 2", seen_req, out_valid, stat);
    end
  endtask

  task automatic test_illegal();
    int cyc; bit to;
    logic seen_req;
    clear_mem();
    mem[0] = 8'hC0;
    do_reset();
    wait_valid(0, cyc, to);
    tests_run++;
    if (to || cyc != 2 || stat !== 3'd4) begin
      tests_failed++;
      $display("FAIL ins_c0: cyc=%0d to=%0b stat=%0d required 2 0 4", cyc, to, stat);
    end
    mem[0] = 8'h67;
    do_reset();
    wait_valid(0, cyc, to);
    tests_run++;
    if (to || icode !== 4'h6 || ifun !== 4'h7 || stat !== 3'd4) begin
      tests_failed++;
      $display("FAIL ins_67: to=%0b ic=%h fn=%h stat=%0d required 6 7 4", to, icode, ifun, stat);
    end
    out_ready = 1'b1;
    seen_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (imem_req) seen_req = 1'b1;
    end
    out_ready = 1'b0;
    tests_run++;
    if (seen_req !== 1'b0 || out_valid !== 1'b0 || stat !== 3'd4) begin
      tests_failed++;
      $display("FAIL ins_stop: req_seen=%b valid=%b stat=%0d required 0 0 4", seen_req, out_valid, stat);
    end
  endtask

  task automatic test_adr();
    int cyc; bit to;
    clear_mem();
    mem[0] = 8'h30; mem[1] = 8'hF5; mem[2] = 8'h00; mem[3] = 8'h77;
    err_en = 1'b1;
    err_addr = 64'h3;
    do_reset();
    wait_valid(0, cyc, to);
    tests_run++;
    if (to || cyc != 5 || stat !== 3'd3 || icode !== 4'h3 || rA !== 4'hF ||
        rB !== 4'h5 || valC !== 64'h0) begin
      tests_failed++;
      $display("FAIL adr: cyc=%0d to=%0b stat=%0d ic=%h rA=%h rB=%h valC=%h required 5 0 3 3 f 5 0",
               cyc, to, stat, icode, rA, rB, valC);
    end
    err_en = 1'b0;
  endtask

  task automatic test_stall();
    int cyc; bit to;
    logic bad;
    clear_mem();
    mem[0] = 8'h30; mem[1] = 8'hF3; mem[2] = 8'h0A;
    do_reset();
    wait_valid(0, cyc, to);
    bad = to;
    pc_new = 64'h80;
    pc_load = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!out_valid || imem_req || valC !== 64'hA || valP !== 64'hA || rB !== 4'h3 || stat !== 3'd1)
        bad = 1'b1;
    end
    pc_load = 1'b0;
    tests_run++;
    if (bad !== 1'b0) begin
      tests_failed++;
      $display("FAIL stall_hold: valid=%b req=%b valC=%h valP=%h required 1 0 a a",
               out_valid, imem_req, valC, valP);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b0 || imem_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL stall_ignore_load: valid=%b req=%b required 0 0", out_valid, imem_req);
    end
    wait_n = 2;
    pulse_pc(64'h60);
    tests_run++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h60) begin
      tests_failed++;
      $display("FAIL pc_load: req=%b addr=%h required 1 60", imem_req, imem_addr);
    end
  endtask

  task automatic test_reset_mid_const();
    mem[8'h60] = 8'h30; mem[8'h61] = 8'hF3; mem[8'h62] = 8'h11;
    for (int i = 0; i < 9; i++) @(negedge clk);
    tests_run++;
    if (imem_req !== 1'b1 || imem_addr <= 64'h62) begin
      tests_failed++;
      $display("FAIL const_progress: req=%b addr=%h required 1 >62", imem_req, imem_addr);
    end
    reset = 1'b1;
    @(negedge clk);
    tests_run++;
    if (imem_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_drop: req=%b required 0", imem_req);
    end
    reset = 1'b0;
    @(negedge clk);
    tests_run++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h0 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_restart: req=%b addr=%h valid=%b required 1 0 0", imem_req, imem_addr, out_valid);
    end
  endtask

  initial begin
    reset = 1'b1; pc_load = 1'b0; pc_new = 64'h0; out_ready = 1'b0;
    wait_n = 0; wcnt = 0; err_en = 1'b0; err_addr = 64'h0;
    clear_mem();
    test_reset();
    test_irmovq();
    test_jmp_wait();
    test_halt();
    test_illegal();
    test_adr();
    test_stall();
    test_reset_mid_const();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
